// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared MIPS control-decode constants, bundle and state types
// for pipe_ctrl_unit and ctrl_decode_comb.
package ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0C;
  localparam logic [5:0] F_BREAK   = 6'h0D;
  localparam logic [5:0] F_MFHI    = 6'h10;
  localparam logic [5:0] F_MFLO    = 6'h12;
  localparam logic [5:0] F_DIV     = 6'h1A;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_SUBU    = 6'h23;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_SLT     = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_LUI  = 4'd3;
  localparam logic [3:0] ALU_MFLO = 4'd4;
  localparam logic [3:0] ALU_MFHI = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b100;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DIV_WAIT,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jump;
    logic       branch;
    logic       syscall;
    logic       jr;
    logic       jal;
    logic [2:0] branch_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: purely combinational instruction word to control
// bundle decode, with DIV/BREAK markers and an undecodable flag.
module ctrl_decode_comb
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [31:0]        instr,
  output ctrl_t              ctrl,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               is_div,
  output logic               is_break,
  output logic               illegal
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [3:0] aop;

  assign op     = instr[31:26];
  assign fn     = instr[5:0];
  assign alu_op = ALUOP_W'(aop);

  always_comb begin
    ctrl     = '0;
    aop      = ALU_AND;
    is_div   = 1'b0;
    is_break = 1'b0;
    illegal  = 1'b0;
    if (instr != '0) begin
      unique case (1'b1)
        (op == OP_SPECIAL): begin
          ctrl.reg_dst   = 1'b1;
          ctrl.reg_write = 1'b1;
          unique case (1'b1)
            (fn == F_SLL):  aop = ALU_SLL;
            (fn == F_SRA):  aop = ALU_SRA;
            (fn == F_MFHI): aop = ALU_MFHI;
            (fn == F_MFLO): aop = ALU_MFLO;
            (fn == F_DIV): begin
              aop    = ALU_DIV;
              is_div = 1'b1;
            end
            (fn == F_ADD || fn == F_ADDU): aop = ALU_ADD;
            (fn == F_SUB || fn == F_SUBU): aop = ALU_SUB;
            (fn == F_AND):  aop = ALU_AND;
            (fn == F_OR):   aop = ALU_OR;
            (fn == F_SLT):  aop = ALU_SLT;
            (fn == F_JR): begin
              ctrl      = '0;
              ctrl.jump = 1'b1;
              ctrl.jr   = 1'b1;
            end
            (fn == F_SYSCALL): begin
              ctrl         = '0;
              ctrl.syscall = 1'b1;
            end
            (fn == F_BREAK): begin
              ctrl     = '0;
              is_break = 1'b1;
            end
            default: begin
              ctrl    = '0;
              illegal = 1'b1;
            end
          endcase
        end
        (op == OP_ADDI || op == OP_ADDIU): begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          aop            = ALU_ADD;
        end
        (op == OP_ANDI): begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          aop            = ALU_AND;
        end
        (op == OP_ORI): begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          aop            = ALU_OR;
        end
        (op == OP_LUI): begin
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          aop            = ALU_LUI;
        end
        (op == OP_LW): begin
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = 1'b1;
          aop             = ALU_ADD;
        end
        (op == OP_SW || op == OP_SB): begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          aop            = ALU_ADD;
        end
        (op == OP_J): ctrl.jump = 1'b1;
        (op == OP_JAL): begin
          ctrl.jump      = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.jal       = 1'b1;
        end
        (op == OP_BEQ): begin
          ctrl.branch    = 1'b1;
          ctrl.branch_op = BR_BEQ;
        end
        (op == OP_BNE): begin
          ctrl.branch    = 1'b1;
          ctrl.branch_op = BR_BNE;
        end
        (op == OP_REGIMM): begin
          ctrl.branch    = 1'b1;
          ctrl.branch_op = BR_BLTZ;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered decode stage with DIV stall and BREAK halt.
// Define CTRL_ILLEGAL_TRAP_EN to also halt on undecodable instructions.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 5,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_instr,
  output logic               in_ready,
  input  logic               flush,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [ALUOP_W+1:0] ex_d,
  output logic [1:0]         mem_d,
  output logic [1:0]         wb_d,
  output logic               jump,
  output logic               branch,
  output logic               syscall,
  output logic               jr,
  output logic               jal,
  output logic [2:0]         branch_op,
  output logic               div_busy,
  output logic               halted,
  output logic               illegal
);

  state_t             state, state_nxt;
  logic [7:0]         cnt, cnt_nxt;
  ctrl_t              d, q;
  logic [ALUOP_W-1:0] d_aop, q_aop;
  logic               d_div, d_brk, d_ill, q_ill;
  logic               accept, halt_req;

  ctrl_decode_comb #(.ALUOP_W(ALUOP_W)) u_dec (
    .instr    (in_instr),
    .ctrl     (d),
    .alu_op   (d_aop),
    .is_div   (d_div),
    .is_break (d_brk),
    .illegal  (d_ill)
  );

  assign in_ready = (state == ST_RUN) & ~flush
                  & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign halt_req = d_brk | d_ill;
`else
  assign halt_req = d_brk;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_RUN: begin
        if (accept && d_div) begin
          state_nxt = ST_DIV_WAIT;
          cnt_nxt   = 8'(DIV_CYCLES);
        end else if (accept && halt_req) begin
          state_nxt = ST_HALT;
        end
      end
      ST_DIV_WAIT: begin
        // leaving on the 1->0 step gives exactly DIV_CYCLES stall cycles
        cnt_nxt = cnt - 8'd1;
        if (cnt <= 8'd1) state_nxt = ST_RUN;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      cnt       <= '0;
      out_valid <= 1'b0;
      q         <= '0;
      q_aop     <= '0;
      q_ill     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        q         <= d;
        q_aop     <= d_aop;
        q_ill     <= d_ill;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign ex_d      = {q.reg_dst, q.alu_src, q_aop};
  assign mem_d     = {q.mem_write, q.mem_read};
  assign wb_d      = {q.reg_write, q.mem_to_reg};
  assign jump      = q.jump;
  assign branch    = q.branch;
  assign syscall   = q.syscall;
  assign jr        = q.jr;
  assign jal       = q.jal;
  assign branch_op = q.branch_op;
  assign illegal   = q_ill;
  assign div_busy  = (state == ST_DIV_WAIT);
  assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: directed vectors with a scoreboard queue and an
// independent output monitor for pipe_ctrl_unit (DIV_CYCLES=4).
module tb_pipe_ctrl_unit;

  localparam int AW = 5;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          flush;
  logic          out_ready;
  logic          out_valid;
  logic [AW+1:0] ex_d;
  logic [1:0]    mem_d;
  logic [1:0]    wb_d;
  logic          jump, branch, syscall, jr, jal;
  logic [2:0]    branch_op;
  logic          div_busy, halted, illegal;

  logic [19:0]   act;
  logic [19:0]   exp_q[$];
  int            checks = 0;
  int            failures = 0;

  pipe_ctrl_unit #(.ALUOP_W(AW), .DIV_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .ex_d      (ex_d),
    .mem_d     (mem_d),
    .wb_d      (wb_d),
    .jump      (jump),
    .branch    (branch),
    .syscall   (syscall),
    .jr        (jr),
    .jal       (jal),
    .branch_op (branch_op),
    .div_busy  (div_busy),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  assign act = {illegal, ex_d, mem_d, wb_d,
                jump, branch, syscall, jr, jal, branch_op};

  function automatic logic [19:0] mk(
    input logic il, rd, as, input logic [4:0] op,
    input logic mw, mr, rw, m2r, jp, br, sc, jrr, jl,
    input logic [2:0] bo);
    return {il, rd, as, op, mw, mr, rw, m2r,
            jp, br, sc, jrr, jl, bo};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, a, e);
    end
  endtask

  // monitor: pops on every real transfer, drops on flush
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (flush) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL mon_unexpected act=%h exp=none", act);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL mon_bundle act=%h exp=%h", act, e);
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [19:0] e,
                      input int budget, output int waited,
                      output int busy);
    bit ok = 1'b0;
    waited = 0;
    busy   = 0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end else begin
        waited++;
        if (div_busy) busy++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic vec(input logic [31:0] ins, input logic [19:0] e);
    int w, b;
    send(ins, e, 4, w, b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    idle(2);
    exp_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, b, acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bundle", 32'(act), 32'd0);
    chk("rst_flags", {29'd0, div_busy, halted, illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    vec(32'h20010005, mk(0,0,1,2, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h3022000F, mk(0,0,1,0, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h34220001, mk(0,0,1,1, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h3C011234, mk(0,0,1,3, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'hAC220004, mk(0,0,1,2, 1,0,0,0, 0,0,0,0,0, 3'b000));
    vec(32'hA0220000, mk(0,0,1,2, 1,0,0,0, 0,0,0,0,0, 3'b000));
    vec(32'h08000010, mk(0,0,0,0, 0,0,0,0, 1,0,0,0,0, 3'b000));
    vec(32'h0C000010, mk(0,0,0,0, 0,0,1,0, 1,0,0,0,1, 3'b000));
    vec(32'h10220003, mk(0,0,0,0, 0,0,0,0, 0,1,0,0,0, 3'b001));
    vec(32'h14220003, mk(0,0,0,0, 0,0,0,0, 0,1,0,0,0, 3'b100));
    vec(32'h04200002, mk(0,0,0,0, 0,0,0,0, 0,1,0,0,0, 3'b110));
    vec(32'h00221820, mk(0,1,0,2, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00221822, mk(0,1,0,6, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00221824, mk(0,1,0,0, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00221825, mk(0,1,0,1, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h0022182A, mk(0,1,0,7, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00021880, mk(0,1,0,8, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00021883, mk(0,1,0,9, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h00001810, mk(0,1,0,5, 0,0,1,0, 0,0,0,0,0, 3'b000));
    vec(32'h03E00008, mk(0,0,0,0, 0,0,0,0, 1,0,0,1,0, 3'b000));
    vec(32'h0000000C, mk(0,0,0,0, 0,0,0,0, 0,0,1,0,0, 3'b000));
    vec(32'h00000000, mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 3'b000));
    vec(32'h0000003F, mk(1,0,0,0, 0,0,0,0, 0,0,0,0,0, 3'b000));
    idle(2);

    // backpressure holds LW
    out_ready = 1'b0;
    vec(32'h8C220000, mk(0,0,1,2, 0,1,1,1, 0,0,0,0,0, 3'b000));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_mem_d", 32'(mem_d), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // flush beats transfer and accept
    vec(32'h20010005, mk(0,0,1,2, 0,0,1,0, 0,0,0,0,0, 3'b000));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h34220001;
    @(negedge clk);
    chk("flush_block", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_clr", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // DIV stall then MFLO
    vec(32'h0043001A, mk(0,1,0,10, 0,0,1,0, 0,0,0,0,0, 3'b000));
    send(32'h00001012, mk(0,1,0,4, 0,0,1,0, 0,0,0,0,0, 3'b000),
         12, w, b);
    chk("div_stall", 32'(w), 32'd4);
    chk("div_busy_cnt", 32'(b), 32'd4);
    idle(2);

    // reset during DIV_WAIT drops in-flight output
    out_ready = 1'b0;
    vec(32'h0043001A, mk(0,1,0,10, 0,0,1,0, 0,0,0,0,0, 3'b000));
    @(negedge clk);
    chk("div_busy_on", 32'(div_busy), 32'd1);
    do_reset();
    @(negedge clk);
    chk("div_rst_busy", 32'(div_busy), 32'd0);
    chk("div_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;

    // undecodable opcode
    vec(32'hFC000000, mk(1,0,0,0, 0,0,0,0, 0,0,0,0,0, 3'b000));
    @(negedge clk);
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_halt", 32'(halted), 32'(TRAP));
    @(posedge clk); #1;
    if (TRAP) do_reset();

    // BREAK halts until reset
    vec(32'h0000000D, mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0, 3'b000));
    @(negedge clk);
    chk("brk_halted", 32'(halted), 32'd1);
    chk("brk_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    acc = 0;
    in_valid = 1'b1;
    in_instr = 32'h20010005;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("halt_block", 32'(acc), 32'd0);
    do_reset();
    @(negedge clk);
    chk("halt_rst", 32'(halted), 32'd0);
    chk("halt_rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    idle(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameter ALUOP_W, default 5, ALU opcode width; ex_d width = ALUOP_W+2.
REQ-002 Parameter DIV_CYCLES, default 32, stall cycles after DIV accept; legal range 1..255.
REQ-003 clk  in  1  sole clock; all state changes on rising edge; one clock, reset synchronous and active-high.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  in_instr valid.
REQ-006 in_instr  in  32  MIPS instruction word.
REQ-007 in_ready  out  1  block accepts in_instr this cycle.
REQ-008 flush  in  1  discard registered output, block accept this cycle.
REQ-009 out_ready  in  1  downstream consumes output.
REQ-010 out_valid  out  1  registered control bundle valid.
REQ-011 ex_d  out  ALUOP_W+2  {RegDst, ALUsrc, ALUop}.
REQ-012 mem_d  out  2  {MemWrite, MemRead}; wb_d  out  2  {RegWrite, MemToReg}.
REQ-013 jump, branch, syscall, jr, jal  out  1 each; branch_op  out  3.
REQ-014 div_busy  out  1  DIV_WAIT active; halted  out  1  HALT state; illegal  out  1  registered undecodable-opcode flag.

Function
REQ-015 Accept = in_valid & in_ready; in_ready = (state==RUN) & ~flush & (~out_valid | out_ready).
REQ-016 Latency one cycle: accepted word's decoded bundle appears in output register, out_valid=1, next cycle.
REQ-017 Output register holds while out_valid & ~out_ready; transfer = out_valid & out_ready; out_valid clears on transfer without new accept.
REQ-018 flush clears out_valid next cycle; flush beats simultaneous transfer/accept; state and counter unaffected.
REQ-019 ALUop codes: AND 0, OR 1, ADD 2, LUI 3, MFLO 4, MFHI 5, SUB 6, SLT 7, SLL 8, SRA 9, DIV 10; branch_op: BEQ 001, BNE 100, BLTZ 110.
REQ-020 I-type: ADDI/ADDIU(08/09) RegWrite,ALUsrc,ADD; ANDI(0C) RegWrite,ALUsrc,AND; ORI(0D) RegWrite,ALUsrc,OR; LUI(0F) RegWrite,ALUsrc,LUI.
REQ-021 Memory: LW(23) MemRead,MemToReg,RegWrite,ALUsrc,ADD; SW(2B), SB(28) MemWrite,ALUsrc,ADD.
REQ-022 Control flow: J(02) jump; JAL(03) jump,RegWrite,jal; BEQ(04)/BNE(05)/REGIMM(01) branch plus branch_op.
REQ-023 SPECIAL(00): RegDst,RegWrite plus funct ALUop (SLL 00, SRA 03, MFHI 10, MFLO 12, DIV 1A, ADD/ADDU 20/21, SUB/SUBU 22/23, AND 24, OR 25, SLT 2A).
REQ-024 JR(funct 08): jump, jr, RegWrite=0; SYSCALL(0C): syscall=1, RegWrite=0.
REQ-025 in_instr==32'h0 is NOP: out_valid=1 with every control bit 0.
REQ-026 States RUN, DIV_WAIT, HALT; RUN->DIV_WAIT on DIV accept, counter loaded DIV_CYCLES.
REQ-027 DIV_WAIT: counter decrements per cycle, in_ready=0, div_busy=1; ->RUN on cycle counter reaches 0 (exactly DIV_CYCLES stall cycles).
REQ-028 RUN->HALT on BREAK(funct 0D) accept; BREAK bundle emitted with all control 0; HALT absorbing until reset, halted=1, in_ready=0.
REQ-029 Output register still drains (out_valid/out_ready) in DIV_WAIT and HALT.
REQ-030 Undefined opcode/funct: bundle all-zero, illegal=1 with that output.

Reset
REQ-031 reset (sync, high) -> state RUN, counter 0, out_valid 0, all bundle bits, illegal, div_busy, halted 0.
REQ-032 Reset mid-DIV_WAIT or HALT returns to RUN next cycle; in-flight output discarded.

Configuration
REQ-033 CTRL_ILLEGAL_TRAP_EN defined: illegal accept also moves RUN->HALT; undefined: illegal flags only, state stays RUN.

Structure
REQ-034 Package ctrl_pkg: opcode/funct constants, ALUop codes, branch_op codes, state enum.
REQ-035 Sub-module ctrl_decode_comb: pure combinational instr->bundle+illegal; pipe_ctrl_unit holds registers, FSM, counter.

Verification
REQ-036 ADDI 0x20010005, out_ready=1 -> next cycle out_valid=1, ex_d={0,1,00010}, wb_d=10.
REQ-037 DIV 0x0043001A, DIV_CYCLES=4 -> in_ready=0, div_busy=1 for 4 cycles, then MFLO 0x00001012 accepted, ALUop 4.
REQ-038 LW 0x8C220000 with out_ready=0 for 3 cycles -> bundle stable, mem_d=01, in_ready=0; released on out_ready=1.
REQ-039 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, instruction not accepted.
REQ-040 BREAK 0x0000000D -> halted=1, in_ready=0 until reset; instr 0xFC000000 -> illegal=1, HALT only with CTRL_ILLEGAL_TRAP_EN.
